// File: rtl/dout_uart_tx.sv
// UART transmitter for the core's 8-bit debug byte: queues every value change and sends it LSB first.
// Define DOUT_UART_TX_PARITY_EN to insert an even-parity bit (8E1 instead of 8N1).
module dout_uart_tx #(
    parameter int CLKS_PER_BIT = 868,
    parameter int FIFO_DEPTH   = 8
) (
    input  logic                          clk_i,
    input  logic                          rst_i,
    input  logic                          en_i,
    input  logic [7:0]                    data_i,
    output logic                          tx_o,
    output logic                          busy_o,
    output logic [$clog2(FIFO_DEPTH):0]   fifo_count_o,
    output logic                          overflow_o
);

    localparam int PW = $clog2(FIFO_DEPTH);
    localparam int TW = (CLKS_PER_BIT > 1) ? $clog2(CLKS_PER_BIT) : 1;
    localparam logic [TW-1:0] BIT_LAST  = TW'(CLKS_PER_BIT - 1);
    localparam logic [PW:0]   FIFO_FULL = (PW + 1)'(FIFO_DEPTH);

    localparam logic [2:0] S_IDLE   = 3'd0;
    localparam logic [2:0] S_START  = 3'd1;
    localparam logic [2:0] S_DATA   = 3'd2;
    localparam logic [2:0] S_STOP   = 3'd3;
`ifdef DOUT_UART_TX_PARITY_EN
    localparam logic [2:0] S_PARITY = 3'd4;
    logic                  r_parity;
`endif

    logic [7:0]    r_prev;
    logic [7:0]    r_mem [FIFO_DEPTH];
    logic [PW-1:0] r_wr_ptr;
    logic [PW-1:0] r_rd_ptr;
    logic [PW:0]   r_count;
    logic          r_overflow;
    logic [2:0]    r_state;
    logic [TW-1:0] r_timer;
    logic [2:0]    r_bit_idx;
    logic [7:0]    r_shift;
    logic          r_tx;
    logic          r_busy;

    logic          w_push_req;
    logic          w_full;
    logic          w_pop;
    logic          w_push;
    logic          w_bit_done;
    logic [7:0]    w_head;

    // Fullness uses the pre-edge count, so a same-cycle pop never rescues a push into a full FIFO.
    assign w_push_req = en_i && (data_i != r_prev);
    assign w_full     = (r_count == FIFO_FULL);
    assign w_pop      = (r_state == S_IDLE) && (r_count != '0);
    assign w_push     = w_push_req && !w_full;
    assign w_bit_done = (r_timer == BIT_LAST);
    assign w_head     = r_mem[r_rd_ptr];

    always_ff @(posedge clk_i or negedge rst_i) begin
        if (!rst_i) begin
            r_prev     <= '0;
            r_wr_ptr   <= '0;
            r_rd_ptr   <= '0;
            r_count    <= '0;
            r_overflow <= 1'b0;
        end else begin
            r_prev <= data_i;
            if (w_push) r_wr_ptr <= r_wr_ptr + PW'(1);
            if (w_pop)  r_rd_ptr <= r_rd_ptr + PW'(1);
            if (w_push_req && w_full) r_overflow <= 1'b1;
            case ({w_push, w_pop})
                2'b10:   r_count <= r_count + (PW + 1)'(1);
                2'b01:   r_count <= r_count - (PW + 1)'(1);
                default: r_count <= r_count;
            endcase
        end
    end

    always_ff @(posedge clk_i) begin
        if (w_push) r_mem[r_wr_ptr] <= data_i;
    end

    // tx is loaded on the same edge as each state change so the line is a clean register output.
    always_ff @(posedge clk_i or negedge rst_i) begin
        if (!rst_i) begin
            r_state   <= S_IDLE;
            r_timer   <= '0;
            r_bit_idx <= '0;
            r_shift   <= '0;
            r_tx      <= 1'b1;
            r_busy    <= 1'b0;
`ifdef DOUT_UART_TX_PARITY_EN
            r_parity  <= 1'b0;
`endif
        end else begin
            case (r_state)
                S_IDLE: begin
                    if (w_pop) begin
                        r_shift   <= w_head;
`ifdef DOUT_UART_TX_PARITY_EN
                        r_parity  <= ^w_head;
`endif
                        r_state   <= S_START;
                        r_timer   <= '0;
                        r_bit_idx <= '0;
                        r_tx      <= 1'b0;
                        r_busy    <= 1'b1;
                    end
                end
                S_START: begin
                    if (w_bit_done) begin
                        r_timer <= '0;
                        r_state <= S_DATA;
                        r_tx    <= r_shift[0];
                    end else begin
                        r_timer <= r_timer + TW'(1);
                    end
                end
                S_DATA: begin
                    if (w_bit_done) begin
                        r_timer <= '0;
                        if (r_bit_idx == 3'd7) begin
                            r_bit_idx <= '0;
`ifdef DOUT_UART_TX_PARITY_EN
                            r_state   <= S_PARITY;
                            r_tx      <= r_parity;
`else
                            r_state   <= S_STOP;
                            r_tx      <= 1'b1;
`endif
                        end else begin
                            r_bit_idx <= r_bit_idx + 3'd1;
                            r_shift   <= {1'b0, r_shift[7:1]};
                            r_tx      <= r_shift[1];
                        end
                    end else begin
                        r_timer <= r_timer + TW'(1);
                    end
                end
`ifdef DOUT_UART_TX_PARITY_EN
                S_PARITY: begin
                    if (w_bit_done) begin
                        r_timer <= '0;
                        r_state <= S_STOP;
                        r_tx    <= 1'b1;
                    end else begin
                        r_timer <= r_timer + TW'(1);
                    end
                end
`endif
                S_STOP: begin
                    if (w_bit_done) begin
                        r_timer <= '0;
                        r_state <= S_IDLE;
                        r_tx    <= 1'b1;
                        r_busy  <= 1'b0;
                    end else begin
                        r_timer <= r_timer + TW'(1);
                    end
                end
                default: begin
                    r_state <= S_IDLE;
                    r_timer <= '0;
                    r_tx    <= 1'b1;
                    r_busy  <= 1'b0;
                end
            endcase
        end
    end

    assign tx_o         = r_tx;
    assign busy_o       = r_busy;
    assign fifo_count_o = r_count;
    assign overflow_o   = r_overflow;

endmodule
